// File: rtl/hazard_pkg.sv
// Shared hazard types and constants for the OTTER hazard and forwarding units.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, LD_STALL, LD_FWD} hazard_state_t;

    typedef enum logic [1:0] {NO_HAZ, MEM_HAZ, WB_HAZ, LOAD_HAZ} hazard_t;

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    // Store-data RS2 counts as a use, so callers pass RS2_USED=1 for stores.
    function automatic logic load_use(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used
    );
        return memread && (rd != 5'd0) &&
               (((rd == rs1) && rs1_used) || ((rd == rs2) && rs2_used));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_mem_watchdog.sv
// MEM_BUSY watchdog: counts consecutive busy cycles and sets a sticky timeout flag.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_MAX = 200
) (
    input  logic CLK,
    input  logic RST,
    input  logic MEM_BUSY,
    output logic MEM_TIMEOUT
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_MAX - 1);

    logic [TIMEOUT_W-1:0] count;

    // Counter parks at LIMIT instead of wrapping; flag stays until reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count       <= '0;
            MEM_TIMEOUT <= 1'b0;
        end else if (!MEM_BUSY) begin
            count <= '0;
        end else if (count == LIMIT) begin
            MEM_TIMEOUT <= 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and memory-freeze arbitration for the OTTER pipeline.
// Optional perf counters (STALL_CNT, FLUSH_CNT) enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_MAX = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] RS1,
    input  logic [4:0] RS2,
    input  logic       RS1_USED,
    input  logic       RS2_USED,
    input  logic       ID_EX_MEMREAD,
    input  logic [4:0] ID_EX_RD,
    input  logic       BR_TAKEN,
    input  logic       MEM_BUSY,
    output logic       PC_WRITE,
    output logic       IF_ID_WRITE,
    output logic       IF_ID_FLUSH,
    output logic       ID_EX_FLUSH,
    output logic       PIPE_HOLD,
    output logic       LD_HAZ,
    output logic       MEM_TIMEOUT
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0] STALL_CNT,
    output logic [31:0] FLUSH_CNT
`endif
);

    hazard_state_t state, state_nxt;
    hazard_t       fwd_sel;
    logic          luse;

    assign luse   = load_use(ID_EX_MEMREAD, ID_EX_RD, RS1, RS2, RS1_USED, RS2_USED);
    assign LD_HAZ = (fwd_sel == LOAD_HAZ);

    // Priority: memory freeze, then branch squash, then load-use stall.
    always_comb begin
        PC_WRITE    = 1'b1;
        IF_ID_WRITE = 1'b1;
        IF_ID_FLUSH = 1'b0;
        ID_EX_FLUSH = 1'b0;
        PIPE_HOLD   = 1'b0;
        state_nxt   = state;
        if (MEM_BUSY) begin
            PIPE_HOLD   = 1'b1;
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
        end else if (BR_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            state_nxt   = RUN;
        end else begin
            case (state)
                LD_STALL: state_nxt = LD_FWD;
                RUN, LD_FWD: begin
                    if (luse) begin
                        PC_WRITE    = 1'b0;
                        IF_ID_WRITE = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        state_nxt   = LD_STALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // fwd_sel follows the state, so it also holds through a memory freeze.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            fwd_sel <= NO_HAZ;
        end else begin
            state   <= state_nxt;
            fwd_sel <= (state_nxt == LD_FWD) ? LOAD_HAZ : NO_HAZ;
        end
    end

    mem_watchdog #(
        .TIMEOUT_W  (TIMEOUT_W),
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_mem_watchdog (
        .CLK        (CLK),
        .RST        (RST),
        .MEM_BUSY   (MEM_BUSY),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (!PC_WRITE)   STALL_CNT <= STALL_CNT + 32'd1;
            if (IF_ID_FLUSH) FLUSH_CNT <= FLUSH_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed, table-driven bench for hazard_stall_unit (TIMEOUT_MAX overridden to 4).
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, id_ex_rd;
    logic       rs1_used, rs2_used, id_ex_memread, br_taken, mem_busy;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, ld_haz, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .TIMEOUT_W  (8),
        .TIMEOUT_MAX(4)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .RS1          (rs1),
        .RS2          (rs2),
        .RS1_USED     (rs1_used),
        .RS2_USED     (rs2_used),
        .ID_EX_MEMREAD(id_ex_memread),
        .ID_EX_RD     (id_ex_rd),
        .BR_TAKEN     (br_taken),
        .MEM_BUSY     (mem_busy),
        .PC_WRITE     (pc_write),
        .IF_ID_WRITE  (if_id_write),
        .IF_ID_FLUSH  (if_id_flush),
        .ID_EX_FLUSH  (id_ex_flush),
        .PIPE_HOLD    (pipe_hold),
        .LD_HAZ       (ld_haz),
        .MEM_TIMEOUT  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
       ,.STALL_CNT    (stall_cnt),
        .FLUSH_CNT    (flush_cnt)
`endif
    );

    // Output vector: {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PIPE_HOLD, LD_HAZ, MEM_TIMEOUT}
    localparam logic [6:0] NORM      = 7'b1100000;
    localparam logic [6:0] STALL     = 7'b0001000;
    localparam logic [6:0] FLUSH     = 7'b1111000;
    localparam logic [6:0] HOLD      = 7'b0000100;
    localparam logic [6:0] FWD       = 7'b1100010;
    localparam logic [6:0] STALL_FWD = 7'b0001010;
    localparam logic [6:0] HOLD_FWD  = 7'b0000110;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       br, busy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t mk(logic [4:0] a, logic [4:0] b, logic u1, logic u2,
                                logic mr, logic [4:0] rd, logic br, logic busy,
                                logic [6:0] exp);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.u1 = u1; v.u2 = u2; v.mr = mr;
        v.rd = rd; v.br = br; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, ld_haz, mem_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rs1_used = v.u1; rs2_used = v.u2;
        id_ex_memread = v.mr; id_ex_rd = v.rd; br_taken = v.br; mem_busy = v.busy;
    endtask

    vec_t idle, ld5;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, NORM);
        ld5  = mk(5, 0, 1, 0, 1, 5, 0, 0, STALL);

        vecs[0]  = idle;                                   // reset state
        vecs[1]  = ld5;                                    // lw x5 ; use x5 via RS1
        vecs[2]  = mk(5, 0, 1, 0, 0, 0, 0, 0, NORM);       // LD_STALL, bubble in EX
        vecs[3]  = mk(6, 0, 1, 0, 0, 0, 0, 0, FWD);        // LD_FWD
        vecs[4]  = idle;                                   // LD_HAZ one cycle only
        vecs[5]  = mk(0, 0, 1, 0, 1, 0, 0, 0, NORM);       // rd = x0
        vecs[6]  = mk(3, 7, 1, 0, 1, 7, 0, 0, NORM);       // RS2 match, unused
        vecs[7]  = mk(3, 7, 1, 1, 1, 7, 0, 0, STALL);      // store-data RS2 use
        vecs[8]  = mk(3, 7, 1, 1, 1, 7, 0, 0, NORM);       // luse ignored in LD_STALL
        vecs[9]  = mk(9, 0, 1, 0, 1, 9, 0, 0, STALL_FWD);  // back-to-back load
        vecs[10] = idle;
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, FWD);
        vecs[12] = mk(5, 0, 1, 0, 1, 5, 1, 0, FLUSH);      // branch beats load stall
        vecs[13] = idle;
        vecs[14] = idle;                                   // no LD_HAZ after squash
        vecs[15] = ld5;
        vecs[16] = mk(5, 0, 1, 0, 0, 0, 0, 1, HOLD);       // freeze in LD_STALL x3
        vecs[17] = mk(5, 0, 1, 0, 0, 0, 0, 1, HOLD);
        vecs[18] = mk(5, 0, 1, 0, 0, 0, 0, 1, HOLD);
        vecs[19] = idle;                                   // still LD_STALL
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, FWD);        // 2nd cycle after release
        vecs[21] = idle;
        vecs[22] = mk(5, 0, 1, 0, 1, 5, 1, 1, HOLD);       // busy masks luse + branch
        vecs[23] = idle;
        vecs[24] = ld5;
        vecs[25] = idle;
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, HOLD_FWD);   // LD_HAZ held through freeze
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, FWD);
        vecs[28] = idle;
        vecs[29] = ld5;
        vecs[30] = mk(0, 0, 0, 0, 0, 0, 1, 0, FLUSH);      // branch in LD_STALL
        vecs[31] = idle;                                   // back to RUN, no LD_HAZ

        drive(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // Reset asserted while in LD_STALL
        drive(ld5);
        @(negedge clk);
        check("rst_pre_stall", 32'(outs()), 32'(STALL));
        @(posedge clk); #1;
        drive(idle);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_after1", 32'(outs()), 32'(NORM));
`ifdef HAZARD_PERF_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_after2", 32'(outs()), 32'(NORM));
        @(posedge clk); #1;

        // Watchdog with TIMEOUT_MAX = 4
        mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("wd_edge%0d", i), 32'(mem_timeout), (i == 4) ? 32'd1 : 32'd0);
        end
        repeat (300) @(posedge clk);
        #1 check("wd_saturate", 32'(mem_timeout), 32'd1);
        mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("wd_sticky", 32'(mem_timeout), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("wd_reset", 32'(mem_timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the load-hazard handshake.
- Detects load-use hazards between ID and EX, inserts the bubble, and holds PC and IF/ID.
- Drives LD_HAZ to the forwarding unit in the cycle the dependent instruction reaches EX.
- Also arbitrates taken-branch flushes and memory-busy freezes; sits beside the forwarding unit in the 5-stage OTTER pipeline.

Parameters:
- TIMEOUT_W, 8: width of the MEM_BUSY watchdog counter.
- TIMEOUT_MAX, 200: consecutive MEM_BUSY cycles before MEM_TIMEOUT sets.

Ports:
- CLK  in  1  pipeline clock
- RST  in  1  synchronous active-high reset
- RS1, RS2  in  5  source register addresses of the ID-stage instruction
- RS1_USED, RS2_USED  in  1  ID instruction actually reads RS1/RS2
- ID_EX_MEMREAD  in  1  instruction in EX is a load
- ID_EX_RD  in  5  destination register of the EX instruction
- BR_TAKEN  in  1  EX-stage branch/jump redirect
- MEM_BUSY  in  1  data memory not ready
- PC_WRITE  out  1  PC may update
- IF_ID_WRITE  out  1  IF/ID register may update
- IF_ID_FLUSH  out  1  load NOP into IF/ID
- ID_EX_FLUSH  out  1  load bubble into ID/EX
- PIPE_HOLD  out  1  freeze all pipeline registers
- LD_HAZ  out  1  to forwarding unit: select load-path forward
- MEM_TIMEOUT  out  1  sticky watchdog error

Behaviour:
- Interface:
  - One clock, CLK; RST synchronous, active-high.
  - All state updates on posedge CLK.
- Reset:
  - state=RUN, watchdog=0, MEM_TIMEOUT=0, LD_HAZ=0.
  - Combinational outputs evaluate with state=RUN and MEM_BUSY as given.
  - RST mid-stall returns to RUN the next edge; no LD_HAZ is emitted afterwards.
- Load-use detect (combinational):
  - luse = ID_EX_MEMREAD && ID_EX_RD!=0 && ((ID_EX_RD==RS1 && RS1_USED) || (ID_EX_RD==RS2 && RS2_USED)).
  - Store-data RS2 counts as use.
- FSM states:
  - RUN: default. If luse and !BR_TAKEN and !MEM_BUSY, then PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1; next state LD_STALL.
  - LD_STALL: load is in MEM, bubble is in EX, dependent is held in ID. Normal outputs (PC_WRITE=1, IF_ID_WRITE=1); luse is ignored. Next state LD_FWD. If BR_TAKEN is asserted here (defensive case), apply flush and go to RUN.
  - LD_FWD: LD_HAZ=1 for exactly this cycle; dependent is in EX, load in WB. luse is evaluated as in RUN, so back-to-back loads are handled. Next state RUN, or LD_STALL on a new luse.
- Default outputs: PC_WRITE=1, IF_ID_WRITE=1, flushes=0, PIPE_HOLD=0, LD_HAZ=0.
- Branch:
  - BR_TAKEN gives IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1 and IF_ID_WRITE=1 in the same cycle.
  - It overrides a load stall in the same cycle, because the ID instruction is squashed; next state RUN.
- MEM_BUSY has highest priority:
  - PIPE_HOLD=1, PC_WRITE=0, IF_ID_WRITE=0, flushes=0.
  - FSM state is frozen, and LD_HAZ keeps its state-derived value.
  - luse and BR_TAKEN are ignored and re-evaluated after MEM_BUSY drops.
- Watchdog:
  - Counts while MEM_BUSY and clears on any cycle with MEM_BUSY=0.
  - When count reaches TIMEOUT_MAX-1 with MEM_BUSY still 1, MEM_TIMEOUT sets.
  - MEM_TIMEOUT stays set until RST; the counter saturates and does not wrap.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs STALL_CNT[31:0] and FLUSH_CNT[31:0].
  - STALL_CNT increments on each cycle of load stall or MEM_BUSY hold.
  - FLUSH_CNT increments on each BR_TAKEN flush cycle.
  - Both clear on RST and wrap modulo 2^32.
- Undefined: no counter ports or logic; all other behaviour identical.

Decomposition:
- Shared package hazard_pkg:
  - hazard_state_t enum {RUN, LD_STALL, LD_FWD}.
  - hazard_t enum {NO_HAZ, MEM_HAZ, WB_HAZ, LOAD_HAZ}, also imported by the forwarding unit.
  - Opcode constants (OP_STORE=7'b0100011, OP_LOAD=7'b0000011).
- One sub-module: mem_watchdog, holding the counter and sticky MEM_TIMEOUT.

Test Plan:
- Load-use: lw x5 in EX, ID reads x5 via RS1 → PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1 that cycle; LD_HAZ=1 exactly two cycles later, one cycle wide.
- No-hazard cases: ID_EX_RD=0, or RS2 match with RS2_USED=0 → no stall, LD_HAZ stays 0.
- Branch priority: luse and BR_TAKEN in the same cycle → IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1; no LD_HAZ follows.
- Memory freeze: MEM_BUSY for 3 cycles during LD_STALL → PIPE_HOLD=1 for 3 cycles, state held; LD_HAZ asserts the 2nd cycle after release.
- Watchdog: TIMEOUT_MAX=4, MEM_BUSY held 4 cycles → MEM_TIMEOUT=1 after the 4th edge; it stays 1 after MEM_BUSY drops until RST.
- Reset mid-stall: RST asserted in LD_STALL → next cycle RUN, LD_HAZ=0; with HAZARD_PERF_CNT_EN defined, counters read 0.
